divider: RTL
============

// Module: divider
// PURPOSE
//  Sequential 32-bit restoring divider; inverse of the shift-add multiplier.
//  Produces one quotient bit per cycle using the shared CLA_32 adder in subtract mode.
//  Sits beside the multiplier in the ALU datapath: start with do_div, result with div_done.
// PARAMETERS
//  WIDTH   32   operand width; only 32 is supported because the datapath uses CLA_32
//  CNT_W   6    iteration counter width, $clog2(WIDTH)+1
// PORTS
//  clk          in   1   single system clock, rising edge
//  reset        in   1   synchronous, active-high
//  a            in   32  dividend, sampled on the start edge
//  b            in   32  divisor, sampled on the start edge
//  do_div       in   1   start request, honoured only in IDLE
//  quot         out  32  quotient, valid while div_done=1 and held until the next start
//  rem          out  32  remainder, same validity as quot
//  div_done     out  1   one-cycle completion pulse
//  div_busy     out  1   high from the start edge until div_done is asserted
//  div_by_zero  out  1   sticky with quot/rem; set when b==0 at start
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, quot=0, rem=0, div_done=0, div_busy=0, div_by_zero=0, counter=0.
//  FSM states: IDLE -> BUSY -> DONE -> IDLE. The DIV_SIGNED_EN build adds FIXUP between BUSY and DONE.
//  IDLE, do_div=1 at edge E:
//   - b!=0: latch D=b, {R,Q}={33'b0,a}, cnt=0, go to BUSY.
//   - b==0: go to DONE with quot=32'hFFFF_FFFF, rem=a, div_by_zero=1.
//  BUSY, one iteration per edge:
//   - {R,Q} <<= 1
//   - T = R - {1'b0,D} using a 33-bit compare with the CLA carry-out as not-borrow
//   - if T>=0: R=T, Q[0]=1; else R is unchanged and Q[0]=0
//   - cnt++; after the 32nd iteration go to DONE (or FIXUP)
//  DONE: div_done=1 for exactly one cycle. quot=Q, rem=R[31:0]. Next edge goes to IDLE.
//  Latency: div_done is high in the cycle after edge E+32 (33 cycles from the start edge).
//   - div-by-zero case: 1 cycle.
//   - DIV_SIGNED_EN build: +1 cycle.
//  do_div while BUSY/FIXUP/DONE: ignored, with no effect on the operation in flight.
//  do_div held high: a new division starts on the first IDLE edge after DONE.
//  Reset mid-operation: abort immediately to the reset values; no div_done pulse.
//  div_by_zero is cleared on the next accepted start.
//  quot and rem change only in DONE or on reset.
//  Invariant (b!=0): a == quot*b + rem and rem < b (unsigned).
// CONFIGURATION
//  DIV_SIGNED_EN defined: a and b are two's complement.
//   - Magnitudes are divided, then FIXUP negates the results.
//   - quot is negative iff signs differ; quot truncates toward zero.
//   - rem takes the sign of the dividend.
//   - Overflow case 32'h8000_0000 / -1: quot=32'h8000_0000, rem=0, no flag.
//   - b==0: quot=-1, rem=a.
//  DIV_SIGNED_EN undefined: unsigned only; no FIXUP state and no sign logic synthesised.
// STRUCTURE
//  Shared package div_pkg:
//   - state encodings S_IDLE, S_BUSY, S_FIXUP, S_DONE
//   - DIV_WIDTH=32, DIV_ITERS=32
//   - DIV_ZERO_QUOT=32'hFFFF_FFFF
//  Sub-module divider_control:
//   - FSM plus iteration counter
//   - outputs: load, shift_sub, fixup, done, busy
//   - mirrors the multiplier's controller split
//  Datapath:
//   - register_n for D (32), R (33), Q (32)
//   - not_gate_32 + CLA_32 with c_in=1 for the subtract
//   - mux_32 for the restore select
// TESTING
//  1. reset; a=100, b=7, do_div pulse
//     -> div_done after 33 cycles; quot=14, rem=2; div_busy low after done.
//  2. a=32'hFFFF_FFFF, b=1 -> quot=32'hFFFF_FFFF, rem=0.
//     a=5, b=9 -> quot=0, rem=5.
//  3. a=1234, b=0 -> div_done next cycle; quot=32'hFFFF_FFFF, rem=1234, div_by_zero=1.
//     The next valid start clears div_by_zero.
//  4. do_div re-pulsed with a=1, b=1 during BUSY -> ignored; the first result is unchanged.
//     Reset asserted at iteration 10 -> outputs zero, no div_done pulse.
//  5. DIV_SIGNED_EN: -7/2 -> quot=-3, rem=-1; 7/-2 -> quot=-3, rem=1; 32'h8000_0000/-1 -> quot=32'h8000_0000, rem=0.
//     Latency is 34 cycles.
//  6. 10k random a,b (b!=0) vs a reference model; check the identity and rem<b.
//     do_div held high gives back-to-back operations with no lost or duplicated div_done.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS) + 1;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } div_state_t;

    // Two's complement negation, used for operand magnitudes and result fixup.
    function automatic logic [DIV_WIDTH-1:0] neg_w(input logic [DIV_WIDTH-1:0] x);
        return ~x + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/divider_if.sv
// Start/result bundle between the ALU and the divider.
interface divider_if;
    import div_pkg::*;

    logic [DIV_WIDTH-1:0] a;
    logic [DIV_WIDTH-1:0] b;
    logic                 do_div;
    logic [DIV_WIDTH-1:0] quot;
    logic [DIV_WIDTH-1:0] rem;
    logic                 div_done;
    logic                 div_busy;
    logic                 div_by_zero;

    modport master (
        output a, b, do_div,
        input  quot, rem, div_done, div_busy, div_by_zero
    );

    modport slave (
        input  a, b, do_div,
        output quot, rem, div_done, div_busy, div_by_zero
    );

endinterface

// File: rtl/divider_control.sv
// Divider sequencer: IDLE -> BUSY (32 iterations) -> [FIXUP] -> DONE -> IDLE.
// FIXUP is only reachable when DIV_SIGNED_EN is defined.
module divider_control
    import div_pkg::*;
#(
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic b_zero,
    output logic load,
    output logic shift_sub,
    output logic last,
    output logic fixup,
    output logic done,
    output logic busy
);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        shift_sub = 1'b0;
        last      = 1'b0;
        fixup     = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = b_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                shift_sub = 1'b1;
                busy      = 1'b1;
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                    last = 1'b1;
`ifdef DIV_SIGNED_EN
                    state_nxt = S_FIXUP;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_FIXUP: begin
`ifdef DIV_SIGNED_EN
                fixup     = 1'b1;
                busy      = 1'b1;
                state_nxt = S_DONE;
`else
                state_nxt = S_IDLE;
`endif
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/divider.sv
// Sequential 32-bit restoring divider, one quotient bit per cycle.
// Build option: DIV_SIGNED_EN -- two's complement operands; magnitudes are
// divided and an extra FIXUP cycle applies the result signs.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);

    logic load, shift_sub, last, fixup, done, busy;
    logic b_zero;

    assign b_zero = (bus.b == '0);

    divider_control #(.CNT_W(CNT_W)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start     (bus.do_div),
        .b_zero    (b_zero),
        .load      (load),
        .shift_sub (shift_sub),
        .last      (last),
        .fixup     (fixup),
        .done      (done),
        .busy      (busy)
    );

    logic [WIDTH-1:0] d_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             dbz_q;

    // Operand magnitudes presented to the unsigned core.
    logic [WIDTH-1:0] a_mag, b_mag;
`ifdef DIV_SIGNED_EN
    logic q_neg_q, r_neg_q;
    assign a_mag = bus.a[WIDTH-1] ? neg_w(bus.a) : bus.a;
    assign b_mag = bus.b[WIDTH-1] ? neg_w(bus.b) : bus.b;
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
`endif

    // One restoring step: shift {R,Q}, trial-subtract D via ~D + 1, keep on no-borrow.
    logic [2*WIDTH:0] rq_sh;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;

    assign rq_sh     = {r_q, q_q} << 1;
    assign r_sh      = rq_sh[2*WIDTH:WIDTH];
    assign trial     = {1'b0, r_sh} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
    assign no_borrow = trial[WIDTH+1];
    assign r_nxt     = no_borrow ? trial[WIDTH:0] : r_sh;
    assign q_nxt     = {rq_sh[WIDTH-1:1], no_borrow};

    // Each build commits results from only one of these strobes.
    logic unused_ctl;
    assign unused_ctl = fixup ^ last;

    // Operand latch, iteration registers and result commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            if (load) begin
                if (b_zero) begin
                    quot_q <= DIV_ZERO_QUOT;
                    rem_q  <= bus.a;
                    dbz_q  <= 1'b1;
                end else begin
                    d_q   <= b_mag;
                    r_q   <= '0;
                    q_q   <= a_mag;
                    dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
                    q_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    r_neg_q <= bus.a[WIDTH-1];
`endif
                end
            end
            if (shift_sub) begin
                r_q <= r_nxt;
                q_q <= q_nxt;
`ifndef DIV_SIGNED_EN
                if (last) begin
                    quot_q <= q_nxt;
                    rem_q  <= r_nxt[WIDTH-1:0];
                end
`endif
            end
`ifdef DIV_SIGNED_EN
            if (fixup) begin
                quot_q <= q_neg_q ? neg_w(q_q) : q_q;
                rem_q  <= r_neg_q ? neg_w(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
            end
`endif
        end
    end

    assign bus.quot        = quot_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.div_done    = done;
    assign bus.div_busy    = busy;

endmodule
